uart_tx_buffer: RTL

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter through a launch / ack / done handshake FSM.
// Optional macro UART_TXBUF_TIMEOUT_EN: WAIT_ACK gives up after ACK_TIMEOUT cycles and flags overflow.
module uart_tx_buffer #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    input  logic                   clr_overflow,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || ACK_TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_tx_buffer: unsupported DEPTH/ACK_TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

    state_t        state_q;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          tx_start_q;
    logic [7:0]    tx_data_q;
    logic          pop, push, drop, tmo_fire;

    // A pop frees a slot on the same edge, so a write to a full FIFO is still taken then.
    assign pop  = (state_q == IDLE) && (count_q != '0) && !tx_busy;
    assign push = wr_valid && ((count_q != FULL_CNT) || pop);
    assign drop = wr_valid && (count_q == FULL_CNT) && !pop;

`ifdef UART_TXBUF_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] tmo_q;

    assign tmo_fire = (state_q == WAIT_ACK) && !tx_busy && (tmo_q == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  tmo_q <= '0;
        else if (state_q != WAIT_ACK) tmo_q <= '0;
        else if (!tx_busy)           tmo_q <= tmo_q + 1'b1;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push) wptr_d = wptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A same-cycle set wins over the clear.
        if (drop || tmo_fire)  overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q    <= LAUNCH;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= mem_q[rptr_q];
                    end
                end
                LAUNCH: begin
                    state_q    <= WAIT_ACK;
                    tx_start_q <= 1'b0;
                end
                WAIT_ACK: begin
                    if (tx_busy)       state_q <= WAIT_DONE;
                    else if (tmo_fire) state_q <= IDLE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    tx_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign count    = count_q;
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;

endmodule
